// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Extended Hamming (SEC-DED) helpers and counter FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int MAX_W = 64;
    localparam int MAX_P = 7;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // Smallest p with 2^p >= width + p + 1.
    function automatic int calc_p(input int width);
        int p;
        p = 0;
        for (int i = 1; i <= MAX_P; i++) begin
            if (p == 0 && (1 << i) >= width + i + 1) begin
                p = i;
            end
        end
        return p;
    endfunction

    // Codeword position of data bit idx; check bits sit on powers of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos_r;
        cnt   = 0;
        pos_r = 0;
        for (int pos = 3; pos <= MAX_W + MAX_P; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == idx) begin
                    pos_r = pos;
                end
                cnt++;
            end
        end
        return pos_r;
    endfunction

    function automatic logic [MAX_P-1:0] hamming_bits(input logic [MAX_W-1:0] data,
                                                      input int width);
        logic [MAX_P-1:0] h;
        h = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width && data[i]) begin
                h = h ^ MAX_P'(data_pos(i));
            end
        end
        return h;
    endfunction

    // Check bits: [p-1:0] Hamming, [p] overall parity. Data must be zero-extended.
    function automatic logic [MAX_P:0] encode(input logic [MAX_W-1:0] data,
                                              input int width, input int p);
        logic [MAX_P-1:0] h;
        logic [MAX_P:0]   c;
        h            = hamming_bits(data, width);
        c            = '0;
        c[MAX_P-1:0] = h;
        c[p]         = (^data) ^ (^h);
        return c;
    endfunction

    function automatic logic [MAX_P-1:0] syndrome(input logic [MAX_W-1:0] data,
                                                  input logic [MAX_P-1:0] check,
                                                  input int width);
        return hamming_bits(data, width) ^ check;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_secded_dec.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_dec
// Description : Combinational SEC-DED decoder: corrects single, flags double.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int P     = 5
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [P:0]       i_check,
    output logic [WIDTH-1:0] o_corrected,
    output logic             o_single,
    output logic             o_double
);

    localparam logic [P-1:0] c_max_pos = P'(WIDTH + P);

    logic [P-1:0] w_syn;
    logic         w_mis;

    assign w_syn = P'(syndrome(MAX_W'(i_data), MAX_P'(i_check[P-1:0]), WIDTH));
    assign w_mis = ^{i_data, i_check};

    // A syndrome beyond the last codeword position can only come from >1 flip.
    assign o_single = w_mis && (w_syn <= c_max_pos);
    assign o_double = (!w_mis && (w_syn != '0)) || (w_mis && (w_syn > c_max_pos));

    for (genvar i = 0; i < WIDTH; i++) begin : g_flip
        localparam logic [P-1:0] c_pos = P'(data_pos(i));
        assign o_corrected[i] = i_data[i] ^ (o_single && (w_syn == c_pos));
    end

endmodule
`default_nettype wire

// File: rtl/hamming_secded_counter.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_counter
// Description : Up/down counter with SEC-DED protected state and scrubbing.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_counter
    import hamming_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 up_down,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    output logic [WIDTH-1:0]     counter,
    output logic                 single_err,
    output logic                 double_err,
    output logic                 fault,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int P  = calc_p(WIDTH);
    localparam int PW = P + 1;
    localparam logic [PW-1:0] c_parity_zero = PW'(encode('0, WIDTH, P));

    logic [WIDTH-1:0]     count_reg;
    logic [P:0]           parity_stored;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_single;
    logic                 r_double;
    logic                 r_wrap;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0]     w_corrected;
    logic                 w_single;
    logic                 w_double;
    logic [WIDTH-1:0]     w_count_nxt;
    logic [P:0]           w_parity_nxt;
    logic                 w_hold;
    logic                 w_wrap_nxt;
    logic                 w_report;

    hamming_secded_dec #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_dec (
        .i_data      (count_reg),
        .i_check     (parity_stored),
        .o_corrected (w_corrected),
        .o_single    (w_single),
        .o_double    (w_double)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = count_reg;
        w_hold      = 1'b1;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = load_value;
            w_hold      = 1'b0;
            w_state_nxt = RUN;
        end else if (r_state == FAULT) begin
            w_state_nxt = FAULT;
        end else if (w_double) begin
            w_state_nxt = FAULT;
        end else begin
            // Rewriting the corrected value every cycle scrubs latent upsets.
            w_hold      = 1'b0;
            w_count_nxt = w_corrected;
            if (enable) begin
                if (up_down) begin
                    w_count_nxt = w_corrected + WIDTH'(1);
                    w_wrap_nxt  = &w_corrected;
                end else begin
                    w_count_nxt = w_corrected - WIDTH'(1);
                    w_wrap_nxt  = ~|w_corrected;
                end
            end
        end
    end

    assign w_parity_nxt = w_hold ? parity_stored
                                 : PW'(encode(MAX_W'(w_count_nxt), WIDTH, P));

    // A frozen double-error word would re-flag every cycle; report it once.
    assign w_report = (r_state == RUN) || load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= '0;
            parity_stored <= c_parity_zero;
            r_single      <= 1'b0;
            r_double      <= 1'b0;
            r_wrap        <= 1'b0;
            r_err_count   <= '0;
        end else begin
            count_reg     <= w_count_nxt;
            parity_stored <= w_parity_nxt;
            r_single      <= w_report && w_single;
            r_double      <= w_report && w_double;
            r_wrap        <= w_wrap_nxt;
            if (w_report && w_single && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign counter    = w_corrected;
    assign single_err = r_single;
    assign double_err = r_double;
    assign fault      = (r_state == FAULT);
    assign wrap       = r_wrap;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_secded_counter
// Description : Directed self-checking bench for hamming_secded_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] counter;
    logic        single_err;
    logic        double_err;
    logic        fault;
    logic        wrap;
    logic [7:0]  err_count;

    logic [5:0]  inj_p;
    logic [15:0] inj_c;
    int          n_cmp;
    int          n_fail;

    hamming_secded_counter #(
        .WIDTH     (16),
        .ERR_CNT_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .counter    (counter),
        .single_err (single_err),
        .double_err (double_err),
        .fault      (fault),
        .wrap       (wrap),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;
        inj_p      = '0;
        inj_c      = '0;

        repeat (2) @(negedge clk);
        chk("rst_counter", 64'(counter), 64'h0);
        chk("rst_parity", 64'(dut.parity_stored), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        chk("rst_errcnt", 64'(err_count), 64'h0);
        reset  = 1'b0;

        // Ten up-steps.
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("cnt10", 64'(counter), 64'h000A);
        chk("cnt10_single", 64'(single_err), 64'h0);
        chk("cnt10_wrap", 64'(wrap), 64'h0);

        // Data bit 3 upset while counting.
        force dut.count_reg = 16'h0002;
        #1;
        chk("upset_masked", 64'(counter), 64'h000A);
        release dut.count_reg;
        @(negedge clk);
        chk("upset_next", 64'(counter), 64'h000B);
        chk("upset_single", 64'(single_err), 64'h1);
        chk("upset_double", 64'(double_err), 64'h0);
        chk("upset_errcnt", 64'(err_count), 64'h1);

        // Check bit 0 upset while idle; encode(0x000B) = 6'h01.
        enable = 1'b0;
        inj_p  = 6'h01 ^ 6'h01;
        force dut.parity_stored = inj_p;
        #1;
        chk("par_upset_cnt", 64'(counter), 64'h000B);
        release dut.parity_stored;
        @(negedge clk);
        chk("par_single", 64'(single_err), 64'h1);
        chk("par_errcnt", 64'(err_count), 64'h2);
        chk("par_scrub", 64'(dut.parity_stored), 64'h01);
        chk("par_cnt", 64'(counter), 64'h000B);
        @(negedge clk);
        chk("par_pulse_end", 64'(single_err), 64'h0);

        // Double upset: stored word for 0x013A with data bits 0 and 1 flipped.
        load       = 1'b1;
        load_value = 16'h013A;
        @(negedge clk);
        load = 1'b0;
        chk("ld_13a", 64'(counter), 64'h013A);
        force dut.count_reg = 16'h0139;
        enable = 1'b1;
        #1;
        release dut.count_reg;
        @(negedge clk);
        chk("dbl_pulse", 64'(double_err), 64'h1);
        chk("dbl_fault", 64'(fault), 64'h1);
        chk("dbl_frozen", 64'(counter), 64'h0139);
        chk("dbl_nosingle", 64'(single_err), 64'h0);
        chk("dbl_errcnt", 64'(err_count), 64'h2);
        @(negedge clk);
        chk("flt_hold_fault", 64'(fault), 64'h1);
        chk("flt_hold_pulse", 64'(double_err), 64'h0);
        chk("flt_hold_cnt", 64'(counter), 64'h0139);
        load       = 1'b1;
        load_value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        chk("flt_exit", 64'(fault), 64'h0);
        chk("flt_ld", 64'(counter), 64'h1234);
        @(negedge clk);
        chk("flt_count", 64'(counter), 64'h1235);

        // Wrap in both directions.
        enable     = 1'b0;
        load       = 1'b1;
        load_value = 16'hFFFF;
        @(negedge clk);
        load = 1'b0;
        chk("ld_ffff", 64'(counter), 64'hFFFF);
        chk("ld_nowrap", 64'(wrap), 64'h0);
        enable  = 1'b1;
        up_down = 1'b1;
        @(negedge clk);
        chk("wrap_up_cnt", 64'(counter), 64'h0000);
        chk("wrap_up", 64'(wrap), 64'h1);
        up_down = 1'b0;
        @(negedge clk);
        chk("wrap_dn_cnt", 64'(counter), 64'hFFFF);
        chk("wrap_dn", 64'(wrap), 64'h1);
        enable = 1'b0;
        @(negedge clk);
        chk("wrap_end", 64'(wrap), 64'h0);
        chk("idle_cnt", 64'(counter), 64'hFFFF);

        // 300 single upsets on top of the two already counted.
        for (int i = 0; i < 300; i++) begin
            inj_p = dut.parity_stored ^ 6'h01;
            force dut.parity_stored = inj_p;
            #1;
            release dut.parity_stored;
            @(negedge clk);
            if (i == 99) begin
                chk("errcnt_102", 64'(err_count), 64'h66);
            end
        end
        chk("errcnt_sat", 64'(err_count), 64'hFF);
        chk("sat_cnt", 64'(counter), 64'hFFFF);

        // Enter FAULT, then reset asynchronously mid-cycle.
        inj_c = dut.count_reg ^ 16'h0003;
        force dut.count_reg = inj_c;
        #1;
        release dut.count_reg;
        @(negedge clk);
        chk("pre_rst_fault", 64'(fault), 64'h1);
        chk("pre_rst_errcnt", 64'(err_count), 64'hFF);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_counter", 64'(counter), 64'h0);
        chk("arst_fault", 64'(fault), 64'h0);
        chk("arst_errcnt", 64'(err_count), 64'h0);
        chk("arst_double", 64'(double_err), 64'h0);
        chk("arst_parity", 64'(dut.parity_stored), 64'h0);
        @(negedge clk);
        reset   = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        @(negedge clk);
        chk("post_rst_step", 64'(counter), 64'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_secded_counter.md
# hamming_secded_counter

Parametrised up/down counter whose state register is protected by an extended Hamming (SEC-DED) code, the successor to the fixed 16-bit Hamming-protected counter. Every cycle the stored codeword is decoded; single-bit upsets are corrected and scrubbed back, and double-bit upsets freeze the counter in a fault state until reloaded. It sits as a self-checking event/time counter in radiation-tolerant datapaths and exposes error telemetry to the status block.

## Interface
- WIDTH, 16: counter data width, 4..64.
- ERR_CNT_W, 8: width of the saturating corrected-error counter.
- P (localparam): smallest p with 2^p >= WIDTH+p+1 (5 for WIDTH=16); stored check bits = P+1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  count one step this cycle.
- up_down  in  1  1 = increment, 0 = decrement.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- counter  out  WIDTH  corrected (decoded) count, combinational from stored codeword.
- single_err  out  1  registered one-cycle pulse: correctable error was detected last cycle.
- double_err  out  1  registered one-cycle pulse: uncorrectable error was detected last cycle.
- fault  out  1  high while FSM is in FAULT.
- wrap  out  1  registered one-cycle pulse: count wrapped (max->0 up, 0->max down).
- err_count  out  ERR_CNT_W  saturating count of single_err events.

## Operation
- State: count_reg[WIDTH-1:0] (data), parity_stored[P:0] ([P-1:0] Hamming, [P] overall parity). Names fixed so benches can force them.
- Encoding: codeword positions 1..WIDTH+P; check bits at powers of two, data bits in ascending index at remaining positions; overall bit = XOR of all data and Hamming bits.
- Decode each cycle: syndrome s, overall mismatch m.
  - s=0, m=0: clean.
  - m=1, s<=WIDTH+P: single; flip data bit if s maps to data, else data already correct.
  - m=0, s!=0, or m=1 with s>WIDTH+P: double.
- FSM: RUN, FAULT.
  - RUN, double detected, no load: no write, -> FAULT.
  - RUN otherwise: next = corrected ± enable; codeword re-encoded and written every cycle (implicit scrub).
  - FAULT: count_reg/parity_stored hold; only load exits to RUN.
- Priority: reset > load > double-error hold > enable.
- load: writes load_value with fresh parity in either state; detection flags still report what was decoded that cycle.
- Arithmetic modulo 2^WIDTH; wrap pulses only on an actual enabled step across the boundary.
- err_count increments on each single detection, saturates at all-ones, cleared only by reset.

## Timing
- Reset (async): count_reg=0, parity_stored=encode(0), state RUN, all pulses 0, err_count 0, counter=0.
- counter reflects stored state with zero latency (combinational correction); a single upset never appears on counter.
- Step latency: enable sampled at edge N -> counter updated after edge N.
- single_err/double_err/wrap assert the cycle after the edge that sampled the condition, for exactly one cycle.
- fault asserts after the edge that sampled the double error; deasserts after the edge sampling load.
- Reset mid-FAULT returns to RUN, counter 0.

## Structure
- Package hamming_pkg: function for P from WIDTH, encode(data) -> check bits, syndrome(data, check) and position-to-data-index mapping, enum typedef {RUN, FAULT}.
- Sub-module hamming_secded_dec (combinational): inputs data and check bits, outputs corrected data, single, double. Top holds registers, FSM, arithmetic, telemetry.

## Test plan
- Reset, enable=1 up for 10 cycles -> counter=0x000A, no flags, err_count=0.
- At 0x000A force count_reg[3] flipped for one cycle, enable=1 -> counter stays 0x000A while forced, next value 0x000B, single_err pulse, err_count=1.
- Force parity_stored[0] flipped, enable=0 -> counter unchanged, single_err pulse, stored parity scrubbed to encode(counter).
- Force two data bits flipped (count_reg=0x0139 vs stored 0x013A's parity) -> double_err pulse, fault=1, counter frozen with enable=1; load 0x1234 -> fault=0, counter=0x1234, then counts.
- load 0xFFFF, up one step -> counter=0x0000, wrap pulse; down one step -> 0xFFFF, wrap pulse.
- Inject 300 single errors with ERR_CNT_W=8 -> err_count saturates at 0xFF; async reset mid-cycle -> all outputs to reset values immediately.
